prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder of the instruction fetch stage; fills the program ROM (word-addressed by PC[15:2]) from a UART byte stream before the CPU runs.
- Accepts bytes from a UART RX byte receiver and assembles little-endian 32-bit words.
- Issues one-cycle write strobes to the instruction memory write port.
- Holds the CPU in reset while a load is in progress.

Parameters:
ADDR_W, 14, instruction-memory word-address width (matches PC[15:2])
TIMEOUT_CYC, 100000, idle clock cycles after the last byte that end a load
CNT_W, 17, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state)
start  input  1  level-sampled request to begin a load; acted on only in IDLE or DONE
rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
rx_data  input  8  received byte
load_active  output  1  1 while a load is in progress; drives CPU reset hold
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  assembled instruction word
word_count  output  ADDR_W+1  words written in the current or last load
done  output  1  level; last load finished
error  output  1  level; last load ended with a partial word or an overflow

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index 0; timeout counter 0. Reset mid-load aborts immediately, with no further writes.
- States: IDLE, WAIT_FIRST, RECV, WRITE, DONE.
- IDLE/DONE, start==1: go to WAIT_FIRST. Clear word_count, done, error and the address. Set load_active=1.
- WAIT_FIRST: wait without timeout for the first rx_valid. Latch the byte into bits [7:0], set byte index to 1, go to RECV.
- RECV: each rx_valid latches rx_data into bits [8*idx+7 : 8*idx] and increments idx.
  - The byte with idx==3 goes to WRITE.
  - The timeout counter clears on every accepted byte and increments otherwise.
- WRITE: lasts exactly one cycle.
  - imem_we=1, with imem_addr and imem_wdata stable; word_count increments.
  - Next cycle, imem_addr increments; return to RECV with idx=0.
  - Write latency: imem_we asserts on the cycle after the posedge that accepted the 4th byte.
- rx_valid during WRITE: the byte is accepted as byte 0 of the next word (no drop).
- Timeout in RECV (counter reaches TIMEOUT_CYC-1 with no byte):
  - idx==0: normal end; done=1.
  - idx!=0: partial word discarded, never written; done=1, error=1.
- Overflow: after a write to address 2^ADDR_W-1, the next accepted byte sets error=1 and done=1 and goes to DONE. That byte is not written. The address never wraps.
- Entering DONE: load_active=0. In DONE and IDLE, rx_valid is ignored.
- start while load_active==1 is ignored.
- imem_wdata holds its last value when imem_we==0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [7:0]: the 8-bit modulo-256 sum of every accepted byte, including discarded partial-word bytes. Cleared on start.
  - Adds output csum_ok [0:0]: high in DONE when the last full word's byte 3 equals the two's complement of the sum of all preceding bytes, i.e. the total sum == 0.
- When undefined: neither port exists and no checksum logic is built.

Decomposition:
- Shared package prog_loader_pkg:
  - State enum (IDLE, WAIT_FIRST, RECV, WRITE, DONE) as localparam 3-bit encodings.
  - Byte-index width constant (2).
- One natural sub-module: loader_timeout_cnt. It is a clearable saturating idle counter with a parameterised terminal count and outputs a one-cycle expire pulse.
- The FSM and the word assembly stay in prog_loader.

Test Plan:
- Reset low mid-load (after 2 words) -> all outputs 0 in the same cycle (async); no imem_we afterwards; state IDLE.
- start, then bytes 0x78,0x56,0x34,0x12 -> one imem_we with addr 0, wdata 0x12345678, one cycle after the 4th byte; word_count=1.
- start, 3 full words, then silence for TIMEOUT_CYC (use TIMEOUT_CYC=16) -> done=1, error=0, load_active=0, word_count=3; addresses 0,1,2 written.
- start, 1 word + 2 bytes, then silence -> exactly one write; done=1, error=1, word_count=1.
- ADDR_W=2, 4 words + 1 extra byte -> writes to addr 0..3; extra byte causes done=1, error=1, word_count=4, no 5th write.
- rx_valid in the WRITE cycle and start during a load -> byte retained as byte 0 of the next word; start has no effect.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and byte-index width.
package prog_loader_pkg;

    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitFirst = 3'd1,
        StRecv      = 3'd2,
        StWrite     = 3'd3,
        StDone      = 3'd4
    } state_e;

endpackage

// File: rtl/loader_timeout_cnt.sv
// Clearable saturating idle counter; pulses expire for one cycle when the count
// steps from TERM-1 to TERM.
module loader_timeout_cnt #(
    parameter int unsigned TERM  = 100000,
    parameter int unsigned CNT_W = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERM - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/prog_loader.sv
// Fills the instruction memory from a UART byte stream, little-endian words, holding the CPU
// in reset meanwhile. Optional running byte checksum enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              load_active,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
`ifdef PROG_LOADER_CHECKSUM_EN
    output logic [7:0]        checksum,
    output logic              csum_ok,
`endif
    output logic              error
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              load_q, load_d;
    logic              expire;

    loader_timeout_cnt #(
        .TERM  (TIMEOUT_CYC),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clr    ((state_q != StRecv) || rx_valid),
        .en     (state_q == StRecv),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        full_d  = full_q;
        done_d  = done_q;
        error_d = error_q;
        load_d  = load_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWaitFirst;
                    idx_d   = '0;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    load_d  = 1'b1;
                end
            end
            StWaitFirst: begin
                if (rx_valid) begin
                    buf_d[7:0] = rx_data;
                    idx_d      = 2'd1;
                    state_d    = StRecv;
                end
            end
            StRecv: begin
                if (rx_valid) begin
                    if (full_q) begin
                        // Memory already full: this byte has nowhere to go.
                        state_d = StDone;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        load_d  = 1'b0;
                    end else begin
                        case (idx_q)
                            2'd0: buf_d[7:0]   = rx_data;
                            2'd1: buf_d[15:8]  = rx_data;
                            2'd2: buf_d[23:16] = rx_data;
                            default: begin
                                wdata_d = {rx_data, buf_q};
                                state_d = StWrite;
                            end
                        endcase
                        idx_d = idx_q + 1'b1;
                    end
                end else if (expire) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    error_d = (idx_q != '0);
                    load_d  = 1'b0;
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
                if (addr_q == ADDR_MAX) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
                state_d = StRecv;
                idx_d   = '0;
                if (rx_valid) begin
                    if (addr_q == ADDR_MAX) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        load_d  = 1'b0;
                    end else begin
                        buf_d[7:0] = rx_data;
                        idx_d      = 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            buf_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
            error_q <= error_d;
            load_q  <= load_d;
        end
    end

    assign load_active = load_q;
    assign imem_we     = (state_q == StWrite);
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign word_count  = count_q;
    assign done        = done_q;
    assign error       = error_q;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start && ((state_q == StIdle) || (state_q == StDone))) begin
            csum_d = '0;
        end else if (rx_valid && ((state_q == StWaitFirst) || (state_q == StRecv) ||
                                  (state_q == StWrite))) begin
            csum_d = csum_q + rx_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
    assign csum_ok  = (state_q == StDone) && (csum_q == 8'h00);
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 4-word memory and a 16-cycle idle timeout.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              load_active;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              error;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    prog_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .load_active (load_active),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .word_count  (word_count),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    // Log every write strobe once per cycle, 1 time unit after the edge.
    always begin
        @(posedge clock);
        #1;
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] exp_data[$]);
        check({tag, "_nwr"}, 32'(wr_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load"}, 32'(load_active), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(error), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_idle_outputs("rst");
        reset = 1'b1;
        @(negedge clock);

        // Ignored bytes in IDLE must not write anything.
        send_byte(8'hAA);
        repeat (2) @(negedge clock);
        check("idle_ignore_nwr", 32'(wr_data.size()), 32'd0);

        // Three words, then idle timeout ends the load cleanly.
        do_start();
        check("a_load", 32'(load_active), 32'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("a_we_lat", 32'(imem_we), 32'd1);
        check("a_addr0", 32'(imem_addr), 32'd0);
        check("a_wdata0", imem_wdata, 32'h1234_5678);
        @(negedge clock);
        check("a_we_off", 32'(imem_we), 32'd0);
        check("a_wc1", 32'(word_count), 32'd1);
        check("a_addr_inc", 32'(imem_addr), 32'd1);
        check("a_wdata_hold", imem_wdata, 32'h1234_5678);
        send_byte(8'hD4); send_byte(8'hC3); send_byte(8'hB2); send_byte(8'hA1);
        repeat (2) @(negedge clock);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
        wait_done("a_done");
        check("a_err", 32'(error), 32'd0);
        check("a_load_off", 32'(load_active), 32'd0);
        check("a_wc3", 32'(word_count), 32'd3);
        check_writes("a", '{32'h1234_5678, 32'hA1B2_C3D4, 32'h0BAD_F00D});

        // One word plus a dangling partial word.
        wr_addr.delete(); wr_data.delete();
        do_start();
        check("b_done_clr", 32'(done), 32'd0);
        check("b_wc_clr", 32'(word_count), 32'd0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (2) @(negedge clock);
        send_byte(8'h55); send_byte(8'h66);
        wait_done("b_done");
        check("b_err", 32'(error), 32'd1);
        check("b_wc1", 32'(word_count), 32'd1);
        check_writes("b", '{32'h4433_2211});

        // Fill all four words, then one extra byte overflows.
        wr_addr.delete(); wr_data.delete();
        do_start();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        repeat (3) @(negedge clock);
        send_byte(8'hEE);
        check("c_done", 32'(done), 32'd1);
        check("c_err", 32'(error), 32'd1);
        check("c_load_off", 32'(load_active), 32'd0);
        check("c_wc4", 32'(word_count), 32'd4);
        repeat (20) @(negedge clock);
        check_writes("c", '{32'h1312_1110, 32'h1716_1514, 32'h1B1A_1918, 32'h1F1E_1D1C});

        // Byte arriving in the WRITE cycle is kept; start mid-load is ignored.
        wr_addr.delete(); wr_data.delete();
        do_start();
        send_byte(8'hBE); send_byte(8'hBA); send_byte(8'hFE); send_byte(8'hCA);
        start = 1'b1;
        send_byte(8'h01);
        start = 1'b0;
        check("d_wc_kept", 32'(word_count), 32'd1);
        check("d_load", 32'(load_active), 32'd1);
        check("d_done", 32'(done), 32'd0);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_done("d_end");
        check("d_err", 32'(error), 32'd0);
        check("d_wc2", 32'(word_count), 32'd2);
        check_writes("d", '{32'hCAFE_BABE, 32'h0403_0201});

        // Asynchronous reset in the middle of the third word.
        wr_addr.delete(); wr_data.delete();
        do_start();
        for (int i = 0; i < 9; i++) send_byte(8'(8'h40 + i));
        check("e_pre_nwr", 32'(wr_data.size()), 32'd2);
        #2 reset = 1'b0;
        #1 check_idle_outputs("e_async");
        @(negedge clock);
        send_byte(8'h50);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("e_nwr", 32'(wr_data.size()), 32'd2);
        check("e_state", 32'(dut.state_q), 32'd0);
        check("e_load", 32'(load_active), 32'd0);
        check("e_wc", 32'(word_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
